// File: rtl/wash_payment_frontend.sv
// Payment front end for the wash controller: debounced coin counting, price check,
// start handshake with acknowledge timeout/refund, and lid-open pause forwarding.
module wash_payment_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CREDIT_W        = 4,
  parameter int PRICE_SINGLE    = 2,
  parameter int PRICE_DOUBLE    = 3,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_raw,
  input  logic                start_btn,
  input  logic                double_sel,
  input  logic                lid_open,
  input  logic                wash_done,
  output logic                coin_in,
  output logic                double_wash,
  output logic                timer_pause,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund
);

  typedef enum logic [1:0] {COLLECT, START, ACK_WAIT, RUN} state_t;

  localparam int SUM_W = CREDIT_W + 1;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
  localparam logic [CREDIT_W-1:0] PRICE_S    = CREDIT_W'(PRICE_SINGLE);
  localparam logic [CREDIT_W-1:0] PRICE_D    = CREDIT_W'(PRICE_DOUBLE);
  localparam logic [7:0]          DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(ACK_TIMEOUT - 1);

  logic coin_s1_q, coin_sync_q;
  logic start_s1_q, start_sync_q, start_prev_q;
  logic dsel_s1_q, dsel_sync_q;
  logic lid_s1_q, lid_sync_q;

  logic [7:0]          db_cnt_q, db_cnt_d;
  logic                coin_db_q, coin_db_d;
  logic                coin_ev_q, coin_ev_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;

  state_t              state_q;
  logic [CREDIT_W-1:0] paid_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic                coin_in_q, double_wash_q, timer_pause_q, refund_q;

  logic                start_ev;
  logic                ack_expired;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] charge;
  logic [CREDIT_W-1:0] refund_amt;
  logic [SUM_W-1:0]    credit_sum;

  assign start_ev    = start_sync_q & ~start_prev_q;
  assign price       = dsel_sync_q ? PRICE_D : PRICE_S;
  assign ack_expired = (to_cnt_q == TO_LAST);
  assign charge      = (state_q == START) ? paid_q : '0;
  assign refund_amt  = (state_q == ACK_WAIT && wash_done && ack_expired) ? paid_q : '0;

  // The counter must see DEBOUNCE_CYCLES differing samples before the level flips.
  always_comb begin
    coin_db_d = coin_db_q;
    db_cnt_d  = '0;
    coin_ev_d = 1'b0;
    if (coin_sync_q != coin_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        coin_db_d = coin_sync_q;
        coin_ev_d = coin_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  // Charge never exceeds credit (checked before START), so the sum cannot underflow.
  always_comb begin
    credit_sum = {1'b0, credit_q} + SUM_W'(coin_ev_q) + {1'b0, refund_amt} - {1'b0, charge};
    credit_d   = (credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : credit_sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coin_s1_q    <= 1'b0;
      coin_sync_q  <= 1'b0;
      start_s1_q   <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      dsel_s1_q    <= 1'b0;
      dsel_sync_q  <= 1'b0;
      lid_s1_q     <= 1'b0;
      lid_sync_q   <= 1'b0;
      db_cnt_q     <= '0;
      coin_db_q    <= 1'b0;
      coin_ev_q    <= 1'b0;
      credit_q     <= '0;
    end else begin
      coin_s1_q    <= coin_raw;
      coin_sync_q  <= coin_s1_q;
      start_s1_q   <= start_btn;
      start_sync_q <= start_s1_q;
      start_prev_q <= start_sync_q;
      dsel_s1_q    <= double_sel;
      dsel_sync_q  <= dsel_s1_q;
      lid_s1_q     <= lid_open;
      lid_sync_q   <= lid_s1_q;
      db_cnt_q     <= db_cnt_d;
      coin_db_q    <= coin_db_d;
      coin_ev_q    <= coin_ev_d;
      credit_q     <= credit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      paid_q        <= '0;
      to_cnt_q      <= '0;
      coin_in_q     <= 1'b0;
      double_wash_q <= 1'b0;
      timer_pause_q <= 1'b0;
      refund_q      <= 1'b0;
    end else begin
      coin_in_q     <= 1'b0;
      refund_q      <= 1'b0;
      timer_pause_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (start_ev && credit_q >= price && wash_done) begin
            state_q       <= START;
            coin_in_q     <= 1'b1;
            double_wash_q <= dsel_sync_q;
            paid_q        <= price;
          end
        end
        START: begin
          state_q  <= ACK_WAIT;
          to_cnt_q <= '0;
        end
        ACK_WAIT: begin
          if (!wash_done) begin
            state_q       <= RUN;
            timer_pause_q <= lid_sync_q;
          end else if (ack_expired) begin
            state_q       <= COLLECT;
            refund_q      <= 1'b1;
            double_wash_q <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        RUN: begin
          if (wash_done) begin
            state_q       <= COLLECT;
            double_wash_q <= 1'b0;
          end else begin
            timer_pause_q <= lid_sync_q;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign coin_in     = coin_in_q;
  assign double_wash = double_wash_q;
  assign timer_pause = timer_pause_q;
  assign credit      = credit_q;
  assign refund      = refund_q;

endmodule

// File: tb/tb_wash_payment_frontend.sv
// Scoreboard bench for wash_payment_frontend: expected start/refund events are queued
// when stimulus is driven and retired by a negedge monitor.
module tb_wash_payment_frontend;

  localparam int DB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, coin_raw, start_btn, double_sel, lid_open, wash_done;
  logic          coin_in, double_wash, timer_pause, refund;
  logic [CW-1:0] credit;

  int n_chk = 0;
  int n_err = 0;

  logic          exp_dbl_q[$];
  logic [CW-1:0] exp_refund_credit_q[$];
  logic          mon_dbl;
  logic [CW-1:0] mon_cred;

  always #5 clk = ~clk;

  wash_payment_frontend #(
    .DEBOUNCE_CYCLES(DB),
    .CREDIT_W       (CW),
    .PRICE_SINGLE   (2),
    .PRICE_DOUBLE   (3),
    .ACK_TIMEOUT    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_raw   (coin_raw),
    .start_btn  (start_btn),
    .double_sel (double_sel),
    .lid_open   (lid_open),
    .wash_done  (wash_done),
    .coin_in    (coin_in),
    .double_wash(double_wash),
    .timer_pause(timer_pause),
    .credit     (credit),
    .refund     (refund)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic insert_coin();
    coin_raw = 1'b1;
    cyc(8);
    coin_raw = 1'b0;
    cyc(8);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    cyc(3);
    start_btn = 1'b0;
  endtask

  task automatic wait_coin_in(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (coin_in === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_coin_in"}, coin_in, 0);
    chk({tag, "_double_wash"}, double_wash, 0);
    chk({tag, "_timer_pause"}, timer_pause, 0);
    chk({tag, "_credit"}, credit, 0);
    chk({tag, "_refund"}, refund, 0);
  endtask

  // Retire queued expectations whenever the DUT emits a start or refund pulse.
  always @(negedge clk) begin
    if (coin_in === 1'b1) begin
      chk("coin_in_was_expected", exp_dbl_q.size() > 0, 1);
      if (exp_dbl_q.size() > 0) begin
        mon_dbl = exp_dbl_q.pop_front();
        chk("double_wash_at_start", double_wash, mon_dbl);
      end
    end
    if (refund === 1'b1) begin
      chk("refund_was_expected", exp_refund_credit_q.size() > 0, 1);
      if (exp_refund_credit_q.size() > 0) begin
        mon_cred = exp_refund_credit_q.pop_front();
        chk("credit_at_refund", credit, mon_cred);
        chk("double_wash_at_refund", double_wash, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int tp_cnt, dw_bad, rl;

    rst_n = 1'b0; coin_raw = 1'b0; start_btn = 1'b0; double_sel = 1'b0;
    lid_open = 1'b0; wash_done = 1'b1;
    cyc(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(2);

    // Pulse shorter than the debounce window is ignored.
    coin_raw = 1'b1;
    cyc(3);
    coin_raw = 1'b0;
    cyc(12);
    chk("short_pulse_credit", credit, 0);

    // Latency: first high sample is edge 1; credit changes at edge 1+DB+2.
    coin_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == DB + 2) chk("latency_before", credit, 0);
      if (k == DB + 3) chk("latency_after", credit, 1);
    end
    coin_raw = 1'b0;
    cyc(12);

    // Single wash, acknowledged.
    insert_coin();
    chk("two_coins", credit, 2);
    exp_dbl_q.push_back(1'b0);
    press_start();
    wait_coin_in(seen);
    chk("single_coin_in_seen", seen, 1);
    @(negedge clk);
    chk("coin_in_one_cycle", coin_in, 0);
    chk("single_charged", credit, 0);
    wash_done = 1'b0;
    cyc(6);
    chk("single_dw_run", double_wash, 0);
    wash_done = 1'b1;
    cyc(2);
    chk("single_dw_idle", double_wash, 0);

    // Double wash refused with credit 2, then accepted with 3.
    insert_coin();
    insert_coin();
    chk("credit_two_again", credit, 2);
    double_sel = 1'b1;
    cyc(3);
    press_start();
    cyc(20);
    chk("double_refused_credit", credit, 2);
    insert_coin();
    chk("credit_three", credit, 3);
    exp_dbl_q.push_back(1'b1);
    press_start();
    wait_coin_in(seen);
    chk("double_coin_in_seen", seen, 1);
    @(negedge clk);
    chk("double_charged", credit, 0);
    wash_done = 1'b0;
    @(negedge clk);
    lid_open = 1'b1;
    double_sel = 1'b0;
    tp_cnt = 0;
    dw_bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (timer_pause === 1'b1) tp_cnt++;
      if (double_wash !== 1'b1) dw_bad++;
      if (k == 5) lid_open = 1'b0;
    end
    chk("timer_pause_run_cycles", tp_cnt, 5);
    chk("double_wash_held_cycles_bad", dw_bad, 0);
    wash_done = 1'b1;
    @(negedge clk);
    chk("run_exit_dw", double_wash, 0);
    chk("run_exit_tp", timer_pause, 0);
    lid_open = 1'b1;
    tp_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (timer_pause === 1'b1) tp_cnt++;
    end
    lid_open = 1'b0;
    chk("timer_pause_collect_cycles", tp_cnt, 0);

    // Controller never acknowledges: refund after ACK_TIMEOUT cycles.
    double_sel = 1'b1;
    insert_coin();
    insert_coin();
    insert_coin();
    chk("refund_setup_credit", credit, 3);
    exp_dbl_q.push_back(1'b1);
    exp_refund_credit_q.push_back(4'd3);
    press_start();
    wait_coin_in(seen);
    chk("refund_coin_in_seen", seen, 1);
    rl = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (refund === 1'b1 && rl == 0) rl = k;
    end
    chk("refund_latency", rl, 5);
    chk("refund_credit_back", credit, 3);
    chk("refund_dw_cleared", double_wash, 0);
    chk("refund_one_cycle", refund, 0);

    // Reset in RUN with a coin accepted mid-run.
    exp_dbl_q.push_back(1'b1);
    press_start();
    wait_coin_in(seen);
    chk("rst_coin_in_seen", seen, 1);
    @(negedge clk);
    wash_done = 1'b0;
    lid_open = 1'b1;
    insert_coin();
    chk("coin_during_run", credit, 1);
    chk("pre_reset_tp", timer_pause, 1);
    chk("pre_reset_dw", double_wash, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("run_reset");
    wash_done = 1'b1;
    lid_open = 1'b0;
    double_sel = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Saturation.
    for (int i = 0; i < 15; i++) insert_coin();
    chk("fifteen_coins", credit, 15);
    insert_coin();
    insert_coin();
    chk("saturated", credit, 15);

    chk("start_queue_drained", exp_dbl_q.size(), 0);
    chk("refund_queue_drained", exp_refund_credit_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
